// File: rtl/sort_loader.sv
// Collects SIZE upstream words into a register buffer, then launches the sorter and
// streams the batch to it one word per cycle, waiting for sort_done before refilling.
module sort_loader #(
    parameter  int SIZE = 8,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic          flush,
    input  logic          sort_done,
    output logic          start,
    output logic [31:0]   data_in,
    output logic [AW:0]   load_idx,
    output logic          busy,
    output logic [15:0]   batch_cnt
);

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        STREAM,
        WAIT_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] str_cnt_q, str_cnt_d;
    logic [15:0]   batch_cnt_q, batch_cnt_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          wr_en;
    logic [31:0]   buf_q [SIZE];

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        str_cnt_d   = str_cnt_q;
        batch_cnt_d = batch_cnt_q;
        wr_en       = 1'b0;
        in_ready    = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = rstn && !flush;
                if (in_valid && in_ready) begin
                    wr_en = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        wr_cnt_d = '0;
                        state_d  = LAUNCH;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            LAUNCH: begin
                str_cnt_d = '0;
                state_d   = STREAM;
            end
            STREAM: begin
                if (str_cnt_q == LAST_IDX) begin
                    str_cnt_d = '0;
                    state_d   = WAIT_DONE;
                end else begin
                    str_cnt_d = str_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (sort_done) begin
                    batch_cnt_d = batch_cnt_q + 16'd1;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        // Abort overrides any transfer, completion or launch decided above.
        if (flush) begin
            state_d     = FILL;
            wr_cnt_d    = '0;
            str_cnt_d   = '0;
            batch_cnt_d = batch_cnt_q;
            wr_en       = 1'b0;
        end
    end

    assign start_d = (state_d == LAUNCH);
    assign busy_d  = (state_d != FILL);

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= FILL;
            wr_cnt_q    <= '0;
            str_cnt_q   <= '0;
            batch_cnt_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            str_cnt_q   <= str_cnt_d;
            batch_cnt_q <= batch_cnt_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    // NOTE: the data buffer has no reset; every entry is rewritten before it is
    // streamed, so clearing it would only cost reset routing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_cnt_q] <= in_data;
        end
    end

    // str_cnt_q is zero in LAUNCH, so word 0 is presented alongside the start pulse.
    always_comb begin
        data_in  = '0;
        load_idx = '0;
        if (state_q == LAUNCH || state_q == STREAM) begin
            data_in  = buf_q[str_cnt_q];
            load_idx = {1'b0, str_cnt_q};
        end
    end

    assign start     = start_q;
    assign busy      = busy_q;
    assign batch_cnt = batch_cnt_q;

endmodule
